// File: rtl/meas_pkg.sv
`default_nettype none
// ============================================================================
// Module   : meas_pkg
// Purpose  : Shared types and constants for the period measurement block.
// Revision : 1.0
// ============================================================================
package meas_pkg;

    localparam int unsigned c_CNT_W       = 28;
    localparam int unsigned c_CLK_FREQ_HZ = 100_000_000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge_det
// Purpose  : Multi-flop synchroniser with registered rising-edge pulse.
// Revision : 1.0
// ============================================================================
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
        end
    end

    // q is taken one flop late so it lines up with the registered rise pulse;
    // the high-time count then starts on the same cycle as the period count.
    assign q    = r_prev;
    assign rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/period_meter.sv
`default_nettype none
// ============================================================================
// Module   : period_meter
// Purpose  : Measures period and high time of a slow signal in clk cycles.
// Revision : 1.0
// ============================================================================
module period_meter
    import meas_pkg::*;
#(
    parameter int               CNT_W       = c_CNT_W,
    parameter logic [CNT_W-1:0] TIMEOUT     = CNT_W'(c_CLK_FREQ_HZ),
    parameter int               SYNC_STAGES = 2,
    parameter int               CONTINUOUS  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_TMO_LAST = TIMEOUT - c_ONE;

    logic             w_sync;
    logic             w_rise;
    state_t           r_state;
    logic [CNT_W-1:0] r_pcnt;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_tcnt;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high_time;
    logic             r_busy;
    logic             r_valid;
    logic             r_timeout;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge_det (
        .clk  (clk),
        .rst  (rst),
        .d    (sig_in),
        .q    (w_sync),
        .rise (w_rise)
    );

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + c_ONE;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_pcnt      <= '0;
            r_hcnt      <= '0;
            r_tcnt      <= '0;
            r_period    <= '0;
            r_high_time <= '0;
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= ARM;
                        r_tcnt  <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ARM, MEAS: begin
                    // A rise takes priority over an expiring timeout.
                    if (w_rise) begin
                        if (r_state == MEAS) begin
                            r_period    <= r_pcnt;
                            r_high_time <= r_hcnt;
                            r_valid     <= 1'b1;
                        end
                        if (r_state == MEAS && CONTINUOUS == 0) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= MEAS;
                            r_pcnt  <= c_ONE;
                            r_hcnt  <= c_ONE;
                            r_tcnt  <= '0;
                        end
                    end else if (r_tcnt == c_TMO_LAST) begin
                        r_timeout <= 1'b1;
                        r_tcnt    <= '0;
                        if (CONTINUOUS == 0) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= ARM;
                        end
                    end else begin
                        r_tcnt <= r_tcnt + c_ONE;
                        if (r_state == MEAS) begin
                            r_pcnt <= sat_inc(r_pcnt);
                            if (w_sync) begin
                                r_hcnt <= sat_inc(r_hcnt);
                            end
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign period    = r_period;
    assign high_time = r_high_time;
    assign valid     = r_valid;
    assign timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_period_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_period_meter
// Purpose  : Directed self-checking bench for period_meter.
// Revision : 1.0
// ============================================================================
module tb_period_meter;

    logic        clk = 1'b0;
    logic        rst;
    logic        sig0, sig1;
    logic        start0, start1;
    logic        busy0, busy1;
    logic        valid0, valid1;
    logic        timeout0, timeout1;
    logic [27:0] period0, period1;
    logic [27:0] high0, high1;

    int  n_chk = 0;
    int  n_err = 0;
    int  nv0 = 0, nt0 = 0, nv1 = 0, nt1 = 0;

    int  hi0 = 5, lo0 = 5, chi0 = 0, clo0 = 0, ph0 = 0;
    int  hi1 = 4, lo1 = 4, chi1 = 0, clo1 = 0, ph1 = 0;
    bit  run0 = 1'b1, lvl0 = 1'b0;

    always #5 clk = ~clk;

    period_meter #(
        .CNT_W       (28),
        .TIMEOUT     (28'd50),
        .SYNC_STAGES (2),
        .CONTINUOUS  (0)
    ) dut0 (
        .clk       (clk),
        .rst       (rst),
        .sig_in    (sig0),
        .start     (start0),
        .busy      (busy0),
        .period    (period0),
        .high_time (high0),
        .valid     (valid0),
        .timeout   (timeout0)
    );

    period_meter #(
        .CNT_W       (28),
        .TIMEOUT     (28'd50),
        .SYNC_STAGES (2),
        .CONTINUOUS  (1)
    ) dut1 (
        .clk       (clk),
        .rst       (rst),
        .sig_in    (sig1),
        .start     (start1),
        .busy      (busy1),
        .period    (period1),
        .high_time (high1),
        .valid     (valid1),
        .timeout   (timeout1)
    );

    // Square-wave sources; new high/low lengths take effect at a period boundary.
    initial begin
        sig0 = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (run0) begin
                if (ph0 == 0) begin
                    chi0 = hi0;
                    clo0 = lo0;
                end
                sig0 = (ph0 < chi0);
                ph0  = (ph0 + 1 == chi0 + clo0) ? 0 : ph0 + 1;
            end else begin
                sig0 = lvl0;
                ph0  = 0;
            end
        end
    end

    initial begin
        sig1 = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ph1 == 0) begin
                chi1 = hi1;
                clo1 = lo1;
            end
            sig1 = (ph1 < chi1);
            ph1  = (ph1 + 1 == chi1 + clo1) ? 0 : ph1 + 1;
        end
    end

    always @(negedge clk) begin
        if (valid0)   nv0++;
        if (timeout0) nt0++;
        if (valid1)   nv1++;
        if (timeout1) nt1++;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic pulse_start0();
        @(posedge clk);
        #1 start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
    endtask

    task automatic pulse_start1();
        @(posedge clk);
        #1 start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
    endtask

    task automatic wait_valid(input bit which, input int budget, output bit got, output int cyc);
        got = 1'b0;
        cyc = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            cyc = i + 1;
            if (which ? valid1 : valid0) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit got, seen;
        int cyc, v, t, c;

        rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy0",    busy0,    0);
        check_eq("rst_valid0",   valid0,   0);
        check_eq("rst_timeout0", timeout0, 0);
        check_eq("rst_period0",  period0,  0);
        check_eq("rst_high0",    high0,    0);
        check_eq("rst_busy1",    busy1,    0);
        check_eq("rst_period1",  period1,  0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(negedge clk);

        // 5/5 single shot
        pulse_start0();
        @(negedge clk);
        check_eq("t1_busy", busy0, 1);
        wait_valid(0, 40, got, cyc);
        check_eq("t1_valid_seen", got, 1);
        check_eq("t1_period", period0, 10);
        check_eq("t1_high", high0, 5);
        check_eq("t1_busy_fall", busy0, 0);
        @(posedge clk);
        v = nv0;
        repeat (40) @(negedge clk);
        @(posedge clk);
        check_eq("t1_single_shot", nv0 - v, 0);

        // 3/7 then 1/1
        @(negedge clk);
        hi0 = 3; lo0 = 7;
        repeat (30) @(negedge clk);
        pulse_start0();
        wait_valid(0, 40, got, cyc);
        check_eq("t2a_valid_seen", got, 1);
        check_eq("t2a_period", period0, 10);
        check_eq("t2a_high", high0, 3);
        hi0 = 1; lo0 = 1;
        repeat (30) @(negedge clk);
        pulse_start0();
        wait_valid(0, 40, got, cyc);
        check_eq("t2b_valid_seen", got, 1);
        check_eq("t2b_period", period0, 2);
        check_eq("t2b_high", high0, 1);

        // Timeout with sig_in held low
        run0 = 1'b0; lvl0 = 1'b0; hi0 = 5; lo0 = 5;
        repeat (10) @(negedge clk);
        @(posedge clk);
        v = nv0; t = nt0;
        pulse_start0();
        @(negedge clk);
        check_eq("t3_armed", busy0, 1);
        c = 0; seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            c++;
            if (timeout0) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("t3_timeout_seen", seen, 1);
        check_eq("t3_timeout_delay", c, 50);
        check_eq("t3_idle", busy0, 0);
        check_eq("t3_period_kept", period0, 2);
        check_eq("t3_high_kept", high0, 1);
        @(negedge clk);
        check_eq("t3_pulse_width", timeout0, 0);
        @(posedge clk);
        check_eq("t3_no_valid", nv0 - v, 0);
        check_eq("t3_timeout_count", nt0 - t, 1);

        // sig_in already high at start; second start during MEAS ignored
        @(negedge clk);
        lvl0 = 1'b1;
        repeat (10) @(negedge clk);
        @(posedge clk);
        v = nv0; t = nt0;
        pulse_start0();
        repeat (20) @(negedge clk);
        check_eq("t5_armed_high", busy0, 1);
        @(posedge clk);
        check_eq("t5_no_false_rise", nv0 - v, 0);
        @(negedge clk);
        run0 = 1'b1;
        repeat (17) @(posedge clk);
        pulse_start0();
        wait_valid(0, 12, got, cyc);
        check_eq("t5_start_ignored", got, 1);
        check_eq("t5_period", period0, 10);
        check_eq("t5_high", high0, 5);
        @(posedge clk);
        check_eq("t5_no_timeout", nt0 - t, 0);

        // Reset in the middle of a measurement
        @(posedge sig0);
        pulse_start0();
        repeat (5) @(posedge clk);
        #1;
        check_eq("t6_busy_pre", busy0, 1);
        rst = 1'b1;
        #2;
        check_eq("t6_rst_busy",    busy0,    0);
        check_eq("t6_rst_valid",   valid0,   0);
        check_eq("t6_rst_timeout", timeout0, 0);
        check_eq("t6_rst_period",  period0,  0);
        check_eq("t6_rst_high",    high0,    0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(negedge clk);
        pulse_start0();
        wait_valid(0, 40, got, cyc);
        check_eq("t6_valid_seen", got, 1);
        check_eq("t6_period", period0, 10);
        check_eq("t6_high", high0, 5);

        // Continuous mode, 4/4 then 6/6
        pulse_start1();
        wait_valid(1, 30, got, cyc);
        check_eq("t4_first_valid", got, 1);
        check_eq("t4_period8", period1, 8);
        check_eq("t4_high4", high1, 4);
        wait_valid(1, 12, got, cyc);
        check_eq("t4_second_valid", got, 1);
        check_eq("t4_interval8", cyc, 8);
        check_eq("t4_period8b", period1, 8);
        check_eq("t4_high4b", high1, 4);
        check_eq("t4_busy", busy1, 1);
        hi1 = 6; lo1 = 6;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_valid(1, 16, got, cyc);
            if (!got) break;
            if (period1 != 28'd8) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("t4_new_period_seen", seen, 1);
        check_eq("t4_period12", period1, 12);
        check_eq("t4_high6", high1, 6);
        check_eq("t4_busy_cont", busy1, 1);
        wait_valid(1, 16, got, cyc);
        check_eq("t4_next_valid", got, 1);
        check_eq("t4_interval12", cyc, 12);
        check_eq("t4_period12b", period1, 12);
        check_eq("t4_high6b", high1, 6);
        @(posedge clk);
        check_eq("t4_no_timeout", nt1, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
